img_rsz_pxl_fwd: RTL and testbench
==================================

# img_rsz_pxl_fwd

Resized pixel forwarder: the stage directly downstream of the image-resizer block buffer. It walks the resized-image block grid in raster order. Each time the block at the cursor carries the "block is executed" flag, it selects that block and pulls the resized pixel over the flush port, which clears the flag. It then emits the pixel on a valid/ready output stream with coordinates and line/frame markers. This block restores raster order for blocks that the compute engine finishes out of order.

## Interface
Parameters:
- RSZ_IMG_WIDTH_SIZE, default 8: resized image width U, in blocks; ≥2.
- RSZ_IMG_HEIGHT_SIZE, default 8: resized image height V, in blocks; ≥2.
- PXL_PRIM_COLOR_NUM, default 3: number of primary colours.
- PXL_PRIM_COLOR_W, default 8: bits per primary colour.
- Derived: XW = $clog2(U), YW = $clog2(V), DW = PXL_PRIM_COLOR_NUM*PXL_PRIM_COLOR_W.

Ports:
- Clk, in, 1: clock.
- Reset, in, 1: reset, synchronous, active-high. Clock Clk.
- BlkIsExec, in, U*V: per-block executed flag; bit index is y*U+x.
- FlushRszPxlData, in, DW: resized pixel of the selected block. Upstream provides it combinationally from the masks; colour c occupies [c*W +: W].
- FlushBlkXMsk, out, U: one-hot column of the cursor block.
- FlushBlkYMsk, out, V: one-hot row of the cursor block.
- FlushVld, out, 1: flush strobe; consumes the cursor block this cycle.
- RszPxlData, out, DW: output pixel.
- RszPxlX, out, XW: output pixel column.
- RszPxlY, out, YW: output pixel row.
- RszPxlEol, out, 1: last pixel of a row (x = U-1).
- RszPxlLast, out, 1: last pixel of a frame (x = U-1, y = V-1).
- RszPxlVld, out, 1: output valid.
- RszPxlRdy, in, 1: downstream ready.

## Operation
- Cursor registers CurX (XW bits) and CurY (YW bits); both reset to 0.
- FlushBlkXMsk = 1<<CurX and FlushBlkYMsk = 1<<CurY at all times. These are never all-zero.
- Free = output storage can accept an entry this cycle (see Configuration).
- FlushVld = BlkIsExec[CurY*U+CurX] & Free. The block has no FSM beyond the cursor and the output occupancy.
- On FlushVld:
  - Capture FlushRszPxlData, CurX, CurY, Eol = (CurX==U-1) and Last = Eol & (CurY==V-1) into output storage.
  - Advance the cursor. CurX wraps U-1→0 and then increments CurY. CurY wraps V-1→0, which starts the next frame with no idle cycle.
- Executed flags of blocks other than the cursor block are ignored until the cursor reaches them. Order is strictly raster.
- Output handshake:
  - An entry transfers when RszPxlVld & RszPxlRdy.
  - While RszPxlVld=1 and RszPxlRdy=0, all output fields hold stable.
  - RszPxlVld never drops without a transfer.
- Simultaneous output transfer and FlushVld in one cycle is legal. The stream sustains 1 pixel/cycle.
- Reset values: CurX=0, CurY=0, RszPxlVld=0, RszPxlData=0, RszPxlX=0, RszPxlY=0, RszPxlEol=0, RszPxlLast=0, FlushVld=0 during reset.
- Reset mid-frame discards all buffered output and returns the cursor to (0,0). Upstream is reset by the same Reset.

## Timing
- FlushVld and the masks are combinational from registered cursor state, BlkIsExec, and Free.
- Upstream clears BlkIsExec of the flushed block on the next edge. The cursor has already moved, so the same block is never flushed twice.
- Latency: BlkIsExec[cursor] rising at edge N, with storage free, gives FlushVld in cycle N and RszPxlVld=1 after edge N+1.
- Without the skid option, Free = !RszPxlVld | RszPxlRdy. This is a combinational path from RszPxlRdy to FlushVld.

## Configuration
- IMG_RSZ_FWD_SKID_EN defined:
  - Output storage is a 2-entry FIFO.
  - Free = (occupancy < 2), which uses registered state only. There is no combinational path from RszPxlRdy to FlushVld or to the masks.
  - Full throughput is kept with a constant ready.
- Undefined: output storage is a single register, and Free is as given in Timing.
- External behaviour is identical in both cases except for the Rdy→FlushVld combinational dependency and up to one extra buffered pixel.

## Test plan
- U=V=4 with all 16 BlkIsExec bits forced high and RszPxlRdy=1:
  - FlushVld is high 16 consecutive cycles.
  - Output is X/Y 0..3 in raster order, Eol on x=3, Last only on (3,3).
  - The cursor returns to (0,0).
- Only block (2,0) executed:
  - FlushVld stays 0 and there is no output.
  - Then set (0,0): exactly one pixel (0,0) is emitted. Then set (1,0): (1,0) and then (2,0) emit in order.
- Output stalled, RszPxlRdy=0 for 10 cycles, with all blocks executed:
  - Without the macro, exactly 1 flush occurs. With the macro, exactly 2.
  - Output data and coordinates are stable throughout. Releasing Rdy drains in order with no loss or duplication.
- Data integrity: drive FlushRszPxlData = {y,x} encoded per block, e.g. 0xA0+4y+x. Each output RszPxlData equals its coordinates' encoding.
- Reset asserted mid-frame with cursor at (1,2) and RszPxlVld=1:
  - The next cycle shows RszPxlVld=0 and all outputs 0.
  - After release, the first flush is block (0,0).
- Back-to-back frames with constant Rdy: pixel (0,0) of frame 2 follows the Last pixel of frame 1 on the next cycle.

Source files
------------

// File: rtl/img_rsz_pxl_fwd.sv
// img_rsz_pxl_fwd -- resized pixel forwarder.
// Walks the resized-image block grid in raster order. When the block at the
// cursor is flagged as executed, the block is flushed from the upstream buffer
// and its pixel is queued onto a valid/ready output stream with coordinates
// and line/frame markers.
// Optional build macro: IMG_RSZ_FWD_SKID_EN selects a 2-entry output FIFO
// whose free indication uses registered state only. When the macro is not
// defined, the block uses a single output register and ready feeds the flush
// strobe combinationally.
module img_rsz_pxl_fwd #(
    parameter  int RSZ_IMG_WIDTH_SIZE  = 8,
    parameter  int RSZ_IMG_HEIGHT_SIZE = 8,
    parameter  int PXL_PRIM_COLOR_NUM  = 3,
    parameter  int PXL_PRIM_COLOR_W    = 8,
    localparam int XW = $clog2(RSZ_IMG_WIDTH_SIZE),
    localparam int YW = $clog2(RSZ_IMG_HEIGHT_SIZE),
    localparam int DW = PXL_PRIM_COLOR_NUM * PXL_PRIM_COLOR_W
) (
    input  logic                                          Clk,
    input  logic                                          Reset,
    input  logic [RSZ_IMG_WIDTH_SIZE*RSZ_IMG_HEIGHT_SIZE-1:0] BlkIsExec,
    input  logic [DW-1:0]                                 FlushRszPxlData,
    output logic [RSZ_IMG_WIDTH_SIZE-1:0]                 FlushBlkXMsk,
    output logic [RSZ_IMG_HEIGHT_SIZE-1:0]                FlushBlkYMsk,
    output logic                                          FlushVld,
    output logic [DW-1:0]                                 RszPxlData,
    output logic [XW-1:0]                                 RszPxlX,
    output logic [YW-1:0]                                 RszPxlY,
    output logic                                          RszPxlEol,
    output logic                                          RszPxlLast,
    output logic                                          RszPxlVld,
    input  logic                                          RszPxlRdy
);

    localparam int IW = $clog2(RSZ_IMG_WIDTH_SIZE * RSZ_IMG_HEIGHT_SIZE);
    // Output entry layout: {data, x, y, eol, last}
    localparam int EW = DW + XW + YW + 2;

    logic [XW-1:0] r_cur_x;
    logic [YW-1:0] r_cur_y;
    logic [IW-1:0] w_idx;
    logic          w_cur_exec;
    logic          w_eol;
    logic          w_last;
    logic          w_free;
    logic          w_flush;
    logic [EW-1:0] w_new_ent;
    logic [EW-1:0] r_head_ent;
    logic          r_vld;

    assign w_idx      = (IW'(r_cur_y) * IW'(RSZ_IMG_WIDTH_SIZE)) + IW'(r_cur_x);
    assign w_cur_exec = BlkIsExec[w_idx];
    assign w_eol      = (r_cur_x == XW'(RSZ_IMG_WIDTH_SIZE - 1));
    assign w_last     = w_eol & (r_cur_y == YW'(RSZ_IMG_HEIGHT_SIZE - 1));
    assign w_new_ent  = {FlushRszPxlData, r_cur_x, r_cur_y, w_eol, w_last};

    // Flush only when the cursor block is ready and storage can take it;
    // held off while in reset so nothing is consumed upstream.
    assign w_flush      = w_cur_exec & w_free & ~Reset;
    assign FlushVld     = w_flush;
    assign FlushBlkXMsk = {{(RSZ_IMG_WIDTH_SIZE-1){1'b0}}, 1'b1} << r_cur_x;
    assign FlushBlkYMsk = {{(RSZ_IMG_HEIGHT_SIZE-1){1'b0}}, 1'b1} << r_cur_y;

    // Raster cursor: advance on every flush, wrapping columns then rows.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_cur_x <= {XW{1'b0}};
            r_cur_y <= {YW{1'b0}};
        end else if (w_flush) begin
            if (w_eol) begin
                r_cur_x <= {XW{1'b0}};
                r_cur_y <= w_last ? {YW{1'b0}} : (r_cur_y + YW'(1));
            end else begin
                r_cur_x <= r_cur_x + XW'(1);
            end
        end
    end

`ifdef IMG_RSZ_FWD_SKID_EN
    logic [EW-1:0] r_sk_ent;
    logic          r_sk_vld;
    logic          w_pop;

    // Occupancy below two is exactly "skid slot empty"; registered only.
    assign w_free = ~r_sk_vld;
    assign w_pop  = r_vld & RszPxlRdy;

    // Two-entry FIFO: head drives the outputs, skid absorbs one extra pixel.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_vld      <= 1'b0;
            r_head_ent <= {EW{1'b0}};
            r_sk_vld   <= 1'b0;
            r_sk_ent   <= {EW{1'b0}};
        end else if (~r_vld | w_pop) begin
            if (r_sk_vld) begin
                r_head_ent <= r_sk_ent;
                r_vld      <= 1'b1;
                r_sk_vld   <= w_flush;
                if (w_flush) begin
                    r_sk_ent <= w_new_ent;
                end
            end else begin
                r_vld <= w_flush;
                if (w_flush) begin
                    r_head_ent <= w_new_ent;
                end
            end
        end else if (w_flush) begin
            r_sk_ent <= w_new_ent;
            r_sk_vld <= 1'b1;
        end
    end
`else
    // Single register: free when empty or being drained this cycle.
    assign w_free = ~r_vld | RszPxlRdy;

    // Single output register; holds while stalled since no flush can occur.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_vld      <= 1'b0;
            r_head_ent <= {EW{1'b0}};
        end else if (w_flush) begin
            r_vld      <= 1'b1;
            r_head_ent <= w_new_ent;
        end else if (RszPxlRdy) begin
            r_vld <= 1'b0;
        end
    end
`endif

    assign RszPxlVld  = r_vld;
    assign RszPxlData = r_head_ent[EW-1 -: DW];
    assign RszPxlX    = r_head_ent[YW+XW+1 -: XW];
    assign RszPxlY    = r_head_ent[YW+1 -: YW];
    assign RszPxlEol  = r_head_ent[1];
    assign RszPxlLast = r_head_ent[0];

endmodule

// File: tb/tb_img_rsz_pxl_fwd.sv
// Testbench for img_rsz_pxl_fwd on a 4x4 block grid with an upstream model
// that holds per-block executed flags and serves pixel data from the masks.
module tb_img_rsz_pxl_fwd;

    localparam int U  = 4;
    localparam int V  = 4;
    localparam int N  = U * V;
    localparam int DW = 24;
`ifdef IMG_RSZ_FWD_SKID_EN
    localparam int STALL_FLUSH = 2;
`else
    localparam int STALL_FLUSH = 1;
`endif

    logic          Clk = 1'b0;
    logic          Reset;
    logic          Rdy;
    logic [N-1:0]  exec_r;
    logic [N-1:0]  set_pulse;
    logic [N-1:0]  clr_v;
    logic [DW-1:0] up_data;
    int            up_x, up_y;

    logic [U-1:0]  FlushBlkXMsk;
    logic [V-1:0]  FlushBlkYMsk;
    logic          FlushVld;
    logic [DW-1:0] RszPxlData;
    logic [1:0]    RszPxlX, RszPxlY;
    logic          RszPxlEol, RszPxlLast, RszPxlVld;

    int tests = 0;
    int fails = 0;

    img_rsz_pxl_fwd #(
        .RSZ_IMG_WIDTH_SIZE (U),
        .RSZ_IMG_HEIGHT_SIZE(V),
        .PXL_PRIM_COLOR_NUM (3),
        .PXL_PRIM_COLOR_W   (8)
    ) dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .BlkIsExec      (exec_r),
        .FlushRszPxlData(up_data),
        .FlushBlkXMsk   (FlushBlkXMsk),
        .FlushBlkYMsk   (FlushBlkYMsk),
        .FlushVld       (FlushVld),
        .RszPxlData     (RszPxlData),
        .RszPxlX        (RszPxlX),
        .RszPxlY        (RszPxlY),
        .RszPxlEol      (RszPxlEol),
        .RszPxlLast     (RszPxlLast),
        .RszPxlVld      (RszPxlVld),
        .RszPxlRdy      (Rdy)
    );

    always #5 Clk = ~Clk;

    function automatic logic [DW-1:0] pix(input int x, input int y);
        logic [7:0] e;
        e = 8'(32'hA0 + 4 * y + x);
        return {e + 8'h20, e + 8'h10, e};
    endfunction

    // Upstream: decode masks, serve data, compute flag to clear on flush.
    always_comb begin
        up_x = 0;
        up_y = 0;
        for (int i = 0; i < U; i++) if (FlushBlkXMsk[i]) up_x = i;
        for (int j = 0; j < V; j++) if (FlushBlkYMsk[j]) up_y = j;
        up_data = pix(up_x, up_y);
        clr_v   = FlushVld ? (16'd1 << (up_y * U + up_x)) : 16'd0;
    end

    // Upstream executed flags: cleared on flush, set by bench pulses.
    always @(posedge Clk) begin
        if (Reset) exec_r <= '0;
        else       exec_r <= (exec_r & ~clr_v) | set_pulse;
    end

    // Monitor: count flushes, record transferred pixels.
    int          flush_cnt = 0;
    int          mon_n = 0;
    logic [29:0] mon_e [0:255];
    always @(negedge Clk) begin
        if (!Reset) begin
            if (FlushVld) flush_cnt <= flush_cnt + 1;
            if (RszPxlVld && Rdy) begin
                mon_e[mon_n[7:0]] <= {RszPxlLast, RszPxlEol, RszPxlY, RszPxlX, RszPxlData};
                mon_n <= mon_n + 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [29:0] exp_ent(input int x, input int y);
        logic eol, last;
        eol  = (x == U - 1);
        last = eol && (y == V - 1);
        return {last, eol, 2'(y), 2'(x), pix(x, y)};
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        set_pulse = '0;
        Rdy = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
    endtask

    typedef struct {
        logic          in_rdy;
        logic          in_pulse;
        logic          exp_flush;
        logic          exp_vld;
        logic [29:0]   exp_e;
    } vec_t;
    vec_t vecs [1:33];

    int f0, m0;

    initial begin
        // Vector table: frame 1 and frame 2 back-to-back, constant ready.
        for (int k = 1; k <= 33; k++) begin
            int p;
            p = (k - 2) % 16;
            vecs[k].in_rdy    = 1'b1;
            vecs[k].in_pulse  = (k == 16);
            vecs[k].exp_flush = (k <= 32);
            vecs[k].exp_vld   = (k >= 2);
            vecs[k].exp_e     = (k >= 2) ? exp_ent(p % 4, p / 4) : 30'd0;
        end

        // Reset state
        Reset = 1'b1;
        set_pulse = '0;
        Rdy = 1'b1;
        tick();
        tick();
        @(negedge Clk);
        chk("rst_vld", RszPxlVld, 1'b0);
        chk("rst_flush", FlushVld, 1'b0);
        chk("rst_fields", {RszPxlLast, RszPxlEol, RszPxlY, RszPxlX, RszPxlData}, 30'd0);
        chk("rst_masks", {FlushBlkYMsk, FlushBlkXMsk}, 8'h11);
        tick();
        Reset = 1'b0;

        // Full frames: all blocks executed, constant ready
        set_pulse = '1;
        tick();
        for (int k = 1; k <= 33; k++) begin
            set_pulse = vecs[k].in_pulse ? '1 : '0;
            Rdy = vecs[k].in_rdy;
            @(negedge Clk);
            chk($sformatf("t1_flush_k%0d", k), FlushVld, vecs[k].exp_flush);
            chk($sformatf("t1_vld_k%0d", k), RszPxlVld, vecs[k].exp_vld);
            if (vecs[k].exp_vld)
                chk($sformatf("t1_pix_k%0d", k),
                    {RszPxlLast, RszPxlEol, RszPxlY, RszPxlX, RszPxlData}, vecs[k].exp_e);
            if (k == 33) chk("t1_cursor_home", {FlushBlkYMsk, FlushBlkXMsk}, 8'h11);
            tick();
        end
        set_pulse = '0;

        // Out-of-order execution: only (2,0), then (0,0), then (1,0)
        do_reset();
        f0 = flush_cnt;
        m0 = mon_n;
        set_pulse = 16'h0004;
        tick();
        set_pulse = '0;
        repeat (6) tick();
        chk("t2_no_flush", flush_cnt - f0, 0);
        chk("t2_no_out", mon_n - m0, 0);
        set_pulse = 16'h0001;
        tick();
        set_pulse = '0;
        repeat (5) tick();
        chk("t2_one_flush", flush_cnt - f0, 1);
        chk("t2_one_out", mon_n - m0, 1);
        chk("t2_pix00", mon_e[m0[7:0]], exp_ent(0, 0));
        set_pulse = 16'h0002;
        tick();
        set_pulse = '0;
        repeat (6) tick();
        chk("t2_three_flush", flush_cnt - f0, 3);
        chk("t2_three_out", mon_n - m0, 3);
        chk("t2_pix10", mon_e[8'(m0 + 1)], exp_ent(1, 0));
        chk("t2_pix20", mon_e[8'(m0 + 2)], exp_ent(2, 0));
        chk("t2_cursor", {FlushBlkYMsk, FlushBlkXMsk}, 8'h18);

        // Output stall with all blocks executed, then drain
        do_reset();
        Rdy = 1'b0;
        f0 = flush_cnt;
        m0 = mon_n;
        set_pulse = '1;
        tick();
        set_pulse = '0;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            if (i >= 1)
                chk($sformatf("t3_hold_%0d", i),
                    {RszPxlVld, RszPxlLast, RszPxlEol, RszPxlY, RszPxlX, RszPxlData},
                    {1'b1, exp_ent(0, 0)});
            tick();
        end
        chk("t3_stall_flush", flush_cnt - f0, STALL_FLUSH);
        chk("t3_stall_out", mon_n - m0, 0);
        Rdy = 1'b1;
        repeat (30) tick();
        chk("t3_drain_cnt", mon_n - m0, 16);
        chk("t3_drain_flush", flush_cnt - f0, 16);
        for (int i = 0; i < 16; i++)
            chk($sformatf("t3_drain_%0d", i), mon_e[8'(m0 + i)], exp_ent(i % 4, i / 4));

        // Reset mid-frame with cursor at (1,2) and output valid
        do_reset();
        set_pulse = '1;
        tick();
        set_pulse = '0;
        repeat (9) tick();
        @(negedge Clk);
        chk("t4_pre_vld", RszPxlVld, 1'b1);
        chk("t4_pre_cursor", {FlushBlkYMsk, FlushBlkXMsk}, 8'h42);
        Reset = 1'b1;
        tick();
        @(negedge Clk);
        chk("t4_rst_vld", RszPxlVld, 1'b0);
        chk("t4_rst_flush", FlushVld, 1'b0);
        chk("t4_rst_fields", {RszPxlLast, RszPxlEol, RszPxlY, RszPxlX, RszPxlData}, 30'd0);
        chk("t4_rst_cursor", {FlushBlkYMsk, FlushBlkXMsk}, 8'h11);
        Reset = 1'b0;
        m0 = mon_n;
        tick();
        set_pulse = '1;
        tick();
        set_pulse = '0;
        repeat (5) tick();
        chk("t4_post_out", (mon_n - m0) > 0, 1'b1);
        chk("t4_first_pix", mon_e[m0[7:0]], exp_ent(0, 0));
        repeat (20) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
